axi_read_master_q: RTL and testbench

Parametrised AXI3 read-master front end. Successor to the fixed two-slot read master.
- Queues local read requests in a REQ_DEPTH FIFO.
- Issues AR transactions while fewer than MAX_OUTSTANDING are in flight, and stalls on ID hazards.
- Tracks outstanding bursts in a slot table and forwards R beats to the local sink.
- Sits between the device-side read logic and the interconnect master port (M*_AR*/M*_R*).

---
 rtl/axi_read_master_q_pkg.sv | 22 ++
 rtl/axi_read_master_q_fifo.sv | 47 ++++
 rtl/axi_read_master_q.sv | 207 ++++++++++++++++++++
 tb/tb_axi_read_master_q.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_read_master_q_pkg.sv
// Shared AXI3 read-channel field widths and response codes for axi_read_master_q.
package axi_rd_pkg;

  localparam int AXI_LEN_W   = 4;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W  = 2;

  localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_W-1:0] RESP_EXOKAY = 2'b01;
  localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [AXI_RESP_W-1:0] RESP_DECERR = 2'b11;

  function automatic logic resp_is_err(input logic [AXI_RESP_W-1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

  function automatic logic resp_is_ok(input logic [AXI_RESP_W-1:0] resp);
    return (resp == RESP_OKAY) || (resp == RESP_EXOKAY);
  endfunction

endpackage

// File: rtl/axi_read_master_q_fifo.sv
// Synchronous request FIFO (module axi_req_fifo) with extra-MSB wrap pointers.
// Head data is read combinationally; push is ignored when full, pop when empty.
module axi_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/axi_read_master_q.sv
// AXI3 read-master front end: request FIFO, registered AR issue, slot table, R forwarding.
// Optional macro AXI_RD_PROTO_CHECK_EN enables sticky beat-protocol checking on proto_err.
module axi_read_master_q
  import axi_rd_pkg::*;
#(
  parameter int BUS_WIDTH       = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int REQ_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETn,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic [ID_WIDTH-1:0]                    req_id,
  input  logic [ADDR_WIDTH-1:0]                  req_addr,
  input  logic [3:0]                             req_len,
  input  logic [2:0]                             req_size,
  input  logic [1:0]                             req_burst,
  output logic [ID_WIDTH-1:0]                    ARID,
  output logic [ADDR_WIDTH-1:0]                  ARADDR,
  output logic [3:0]                             ARLEN,
  output logic [2:0]                             ARSIZE,
  output logic [1:0]                             ARBURST,
  output logic                                   ARVALID,
  input  logic                                   ARREADY,
  input  logic [ID_WIDTH-1:0]                    RID,
  input  logic [BUS_WIDTH-1:0]                   RDATA,
  input  logic [1:0]                             RRESP,
  input  logic                                   RLAST,
  input  logic                                   RVALID,
  output logic                                   RREADY,
  output logic                                   rd_valid,
  input  logic                                   rd_ready,
  output logic [ID_WIDTH-1:0]                    rd_id,
  output logic [BUS_WIDTH-1:0]                   rd_data,
  output logic [1:0]                             rd_resp,
  output logic                                   rd_last,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   proto_err
);

  localparam int REQ_W  = ID_WIDTH + ADDR_WIDTH + AXI_LEN_W + AXI_SIZE_W + AXI_BURST_W;
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING+1);
  localparam int SLOT_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [OUT_W-1:0] MAX_O = OUT_W'(MAX_OUTSTANDING);

  logic [REQ_W-1:0]       w_head;
  logic                   w_full;
  logic                   w_empty;
  logic [ID_WIDTH-1:0]    w_h_id;
  logic [ADDR_WIDTH-1:0]  w_h_addr;
  logic [AXI_LEN_W-1:0]   w_h_len;
  logic [AXI_SIZE_W-1:0]  w_h_size;
  logic [AXI_BURST_W-1:0] w_h_burst;

  logic                   r_ar_valid;
  logic [ID_WIDTH-1:0]    r_arid;
  logic [ADDR_WIDTH-1:0]  r_araddr;
  logic [AXI_LEN_W-1:0]   r_arlen;
  logic [AXI_SIZE_W-1:0]  r_arsize;
  logic [AXI_BURST_W-1:0] r_arburst;

  logic [MAX_OUTSTANDING-1:0] r_slot_vld;
  logic [ID_WIDTH-1:0]        r_slot_id   [MAX_OUTSTANDING];
  logic [AXI_LEN_W-1:0]       r_slot_left [MAX_OUTSTANDING];
  logic [OUT_W-1:0]           r_out;

  logic                 w_hazard;
  logic                 w_match;
  logic [SLOT_W-1:0]    w_match_idx;
  logic [SLOT_W-1:0]    w_free_idx;
  logic [AXI_LEN_W-1:0] w_cur_left;
  logic                 w_r_hs;
  logic                 w_m_hs;
  logic                 w_free;
  logic                 w_ar_hs;
  logic                 w_load;
  logic [OUT_W-1:0]     w_out_after;

  axi_req_fifo #(.WIDTH(REQ_W), .DEPTH(REQ_DEPTH)) u_fifo (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .i_push  (req_valid),
    .i_data  ({req_id, req_addr, req_len, req_size, req_burst}),
    .i_pop   (w_load),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign req_ready = !w_full;
  assign {w_h_id, w_h_addr, w_h_len, w_h_size, w_h_burst} = w_head;

  // The AR register counts as in flight for hazards: it becomes a slot on handshake.
  always_comb begin
    w_hazard    = r_ar_valid && (r_arid == w_h_id);
    w_match     = 1'b0;
    w_match_idx = '0;
    w_free_idx  = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (r_slot_vld[i] && (r_slot_id[i] == w_h_id)) w_hazard = 1'b1;
      if (r_slot_vld[i] && (r_slot_id[i] == RID)) begin
        w_match     = 1'b1;
        w_match_idx = SLOT_W'(i);
      end
    end
    for (int i = MAX_OUTSTANDING-1; i >= 0; i--) begin
      if (!r_slot_vld[i]) w_free_idx = SLOT_W'(i);
    end
  end

  assign w_cur_left = r_slot_left[w_match_idx];
  assign RREADY     = w_match ? rd_ready : 1'b1;
  assign rd_valid   = RVALID && w_match;
  assign rd_id      = RID;
  assign rd_data    = RDATA;
  assign rd_resp    = RRESP;
  assign rd_last    = RLAST;

  assign w_r_hs  = RVALID && RREADY;
  assign w_m_hs  = w_r_hs && w_match;
  assign w_ar_hs = r_ar_valid && ARREADY;

`ifdef AXI_RD_PROTO_CHECK_EN
  assign w_free = w_m_hs && RLAST;
`else
  assign w_free = w_m_hs && (RLAST || (w_cur_left == '0));
`endif

  // Headroom includes the AR handshaking this cycle so the table can never overflow.
  assign w_out_after = r_out + OUT_W'(w_ar_hs) - OUT_W'(w_free);
  assign w_load      = (!r_ar_valid || w_ar_hs) && !w_empty &&
                       (w_out_after < MAX_O) && !w_hazard;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_ar_valid <= 1'b0;
      r_arid     <= '0;
      r_araddr   <= '0;
      r_arlen    <= '0;
      r_arsize   <= '0;
      r_arburst  <= '0;
    end else if (w_load) begin
      r_ar_valid <= 1'b1;
      r_arid     <= w_h_id;
      r_araddr   <= w_h_addr;
      r_arlen    <= w_h_len;
      r_arsize   <= w_h_size;
      r_arburst  <= w_h_burst;
    end else if (w_ar_hs) begin
      r_ar_valid <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_slot_vld <= '0;
      r_out      <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_slot_id[i]   <= '0;
        r_slot_left[i] <= '0;
      end
    end else begin
      r_out <= w_out_after;
      if (w_m_hs) begin
        if (w_free)
          r_slot_vld[w_match_idx] <= 1'b0;
        else if (w_cur_left != '0)
          r_slot_left[w_match_idx] <= w_cur_left - AXI_LEN_W'(1);
      end
      if (w_ar_hs) begin
        r_slot_vld[w_free_idx]  <= 1'b1;
        r_slot_id[w_free_idx]   <= r_arid;
        r_slot_left[w_free_idx] <= r_arlen;
      end
    end
  end

`ifdef AXI_RD_PROTO_CHECK_EN
  logic r_proto_err;
  logic w_perr;

  assign w_perr = (w_r_hs && !w_match) ||
                  (w_m_hs && RLAST && (w_cur_left != '0)) ||
                  (w_m_hs && !RLAST && (w_cur_left == '0));

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_proto_err <= 1'b0;
    else if (w_perr) r_proto_err <= 1'b1;
  end

  assign proto_err = r_proto_err;
`else
  assign proto_err = 1'b0;
`endif

  assign ARVALID     = r_ar_valid;
  assign ARID        = r_arid;
  assign ARADDR      = r_araddr;
  assign ARLEN       = r_arlen;
  assign ARSIZE      = r_arsize;
  assign ARBURST     = r_arburst;
  assign outstanding = r_out;

endmodule

// File: tb/tb_axi_read_master_q.sv
// Directed bench for axi_read_master_q with AR and R scoreboards checked on the falling edge.
module tb_axi_read_master_q;
  import axi_rd_pkg::*;

`ifdef AXI_RD_PROTO_CHECK_EN
  localparam logic PERR_EXP = 1'b1;
`else
  localparam logic PERR_EXP = 1'b0;
`endif

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        req_valid, req_ready;
  logic [3:0]  req_id;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic [2:0]  req_size;
  logic [1:0]  req_burst;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID, ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST, RVALID, RREADY;
  logic        rd_valid, rd_ready;
  logic [3:0]  rd_id;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic        rd_last;
  logic [1:0]  outstanding;
  logic        proto_err;

  int checks   = 0;
  int failures = 0;
  int ar_hs_cnt = 0;
  logic [44:0] exp_ar[$];
  logic [38:0] exp_rd[$];

  always #5 ACLK = ~ACLK;

  axi_read_master_q dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id), .req_addr(req_addr),
    .req_len(req_len), .req_size(req_size), .req_burst(req_burst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_id(rd_id), .rd_data(rd_data),
    .rd_resp(rd_resp), .rd_last(rd_last),
    .outstanding(outstanding), .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge ACLK) begin
    if (ARESETn === 1'b1 && ARVALID === 1'b1 && ARREADY === 1'b1) begin
      ar_hs_cnt++;
      chk("ar_expected", 64'(exp_ar.size() > 0), 64'd1);
      if (exp_ar.size() > 0)
        chk("ar_payload", {ARID, ARADDR, ARLEN, ARSIZE, ARBURST}, exp_ar.pop_front());
    end
    if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
      chk("rd_expected", 64'(exp_rd.size() > 0), 64'd1);
      if (exp_rd.size() > 0)
        chk("rd_beat", {rd_id, rd_data, rd_resp, rd_last}, exp_rd.pop_front());
    end
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic push(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
    req_valid = 1'b1; req_id = id; req_addr = addr; req_len = len;
    req_size = 3'd2; req_burst = 2'd1;
    @(negedge ACLK);
    chk("push_req_ready", req_ready, 1);
    @(posedge ACLK);
    exp_ar.push_back({id, addr, len, 3'd2, 2'd1});
    #1;
    req_valid = 1'b0;
  endtask

  task automatic beat(input logic [3:0] id, input logic [31:0] data, input logic last,
                      input logic fwd);
    int n;
    RVALID = 1'b1; RID = id; RDATA = data; RRESP = RESP_OKAY; RLAST = last;
    if (fwd) exp_rd.push_back({id, data, RESP_OKAY, last});
    n = 0;
    @(negedge ACLK);
    while (!RREADY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    chk("r_handshake", RREADY, 1);
    @(posedge ACLK);
    #1;
    RVALID = 1'b0; RLAST = 1'b0;
  endtask

  task automatic wait_out(input logic [1:0] n, input string tag);
    int k;
    k = 0;
    @(negedge ACLK);
    while (outstanding !== n && k < 20) begin
      @(negedge ACLK);
      k++;
    end
    chk(tag, outstanding, n);
    step();
  endtask

  initial begin
    int hs0;
    int k;
    ARESETn = 1'b0; req_valid = 1'b0; req_id = '0; req_addr = '0; req_len = '0;
    req_size = '0; req_burst = '0; ARREADY = 1'b1; RID = '0; RDATA = '0; RRESP = '0;
    RLAST = 1'b0; RVALID = 1'b0; rd_ready = 1'b1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_araddr", ARADDR, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_proto_err", proto_err, 0);
    step();
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("rel_req_ready", req_ready, 1);
    step();

    // single request, four beats
    push(4'd3, 32'h100, 4'd3);
    @(negedge ACLK);
    chk("t1_arvalid_early", ARVALID, 0);
    @(negedge ACLK);
    chk("t1_arvalid", ARVALID, 1);
    chk("t1_out0", outstanding, 0);
    @(negedge ACLK);
    chk("t1_out1", outstanding, 1);
    chk("t1_arvalid_drop", ARVALID, 0);
    step();
    beat(4'd3, 32'hA000_0000, 1'b0, 1'b1);
    beat(4'd3, 32'hA000_0001, 1'b0, 1'b1);
    beat(4'd3, 32'hA000_0002, 1'b0, 1'b1);
    beat(4'd3, 32'hA000_0003, 1'b1, 1'b1);
    @(negedge ACLK);
    chk("t1_out_end", outstanding, 0);
    step();

    // four requests against two slots
    hs0 = ar_hs_cnt;
    push(4'd1, 32'h200, 4'd1);
    push(4'd2, 32'h210, 4'd1);
    push(4'd5, 32'h250, 4'd1);
    push(4'd6, 32'h260, 4'd1);
    repeat (5) step();
    @(negedge ACLK);
    chk("t2_ar_count", ar_hs_cnt - hs0, 2);
    chk("t2_out", outstanding, 2);
    chk("t2_req_ready", req_ready, 1);
    chk("t2_arvalid_idle", ARVALID, 0);
    chk("t2_fifo_left", exp_ar.size(), 2);
    step();
    beat(4'd1, 32'hB100, 1'b0, 1'b1);
    beat(4'd1, 32'hB101, 1'b1, 1'b1);
    beat(4'd2, 32'hB200, 1'b0, 1'b1);
    beat(4'd2, 32'hB201, 1'b1, 1'b1);
    wait_out(2'd2, "t2_refill");
    beat(4'd5, 32'hB500, 1'b0, 1'b1);
    beat(4'd5, 32'hB501, 1'b1, 1'b1);
    wait_out(2'd1, "t2_one_left");

    // ID hazard: id 6 still in flight
    push(4'd6, 32'h600, 4'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      chk("t3_stall", ARVALID, 0);
    end
    step();
    beat(4'd6, 32'hB600, 1'b0, 1'b1);
    beat(4'd6, 32'hB601, 1'b1, 1'b1);
    k = 0;
    @(negedge ACLK);
    while (ARVALID !== 1'b1 && k < 10) begin
      @(negedge ACLK);
      k++;
    end
    chk("t3_issue", ARVALID, 1);
    step();
    wait_out(2'd1, "t3_out");
    beat(4'd6, 32'hC600, 1'b1, 1'b1);
    wait_out(2'd0, "t3_out_end");

    // AR backpressure fills the FIFO
    ARREADY = 1'b0;
    push(4'd7, 32'h700, 4'd0);
    push(4'd8, 32'h800, 4'd0);
    push(4'd9, 32'h900, 4'd0);
    push(4'd10, 32'hA00, 4'd0);
    push(4'd11, 32'hB00, 4'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("t4_arvalid_hold", ARVALID, 1);
      chk("t4_araddr_hold", ARADDR, 32'h700);
    end
    chk("t4_req_full", req_ready, 0);
    step();
    ARREADY = 1'b1;
    wait_out(2'd2, "t4_two_a");
    beat(4'd7, 32'hD007, 1'b1, 1'b1);
    beat(4'd8, 32'hD008, 1'b1, 1'b1);
    wait_out(2'd2, "t4_two_b");
    beat(4'd9, 32'hD009, 1'b1, 1'b1);
    beat(4'd10, 32'hD00A, 1'b1, 1'b1);
    wait_out(2'd1, "t4_last");
    beat(4'd11, 32'hD00B, 1'b1, 1'b1);
    wait_out(2'd0, "t4_drained");

    // early RLAST, then an unmatched beat
    @(negedge ACLK);
    chk("t5_perr_clean", proto_err, 0);
    step();
    push(4'd4, 32'h400, 4'd3);
    wait_out(2'd1, "t5_out");
    beat(4'd4, 32'hE400, 1'b0, 1'b1);
    beat(4'd4, 32'hE401, 1'b1, 1'b1);
    @(negedge ACLK);
    chk("t5_early_last_free", outstanding, 0);
    chk("t5_perr_early_last", proto_err, PERR_EXP);
    step();
    RVALID = 1'b1; RID = 4'd9; RDATA = 32'hDEAD; RLAST = 1'b1;
    @(negedge ACLK);
    chk("t5_unmatched_rready", RREADY, 1);
    chk("t5_unmatched_rd_valid", rd_valid, 0);
    step();
    RVALID = 1'b0; RLAST = 1'b0;
    @(negedge ACLK);
    chk("t5_perr_sticky", proto_err, PERR_EXP);
    step();

    // reset mid-burst
    push(4'd2, 32'h2000, 4'd3);
    wait_out(2'd1, "t6_out");
    beat(4'd2, 32'hF000, 1'b0, 1'b1);
    RVALID = 1'b1; RID = 4'd2; RDATA = 32'hF001; RLAST = 1'b0;
    ARESETn = 1'b0;
    #1;
    chk("t6_rst_arvalid", ARVALID, 0);
    chk("t6_rst_out", outstanding, 0);
    chk("t6_rst_rd_valid", rd_valid, 0);
    chk("t6_rst_rready", RREADY, 1);
    chk("t6_rst_perr", proto_err, 0);
    chk("t6_rst_araddr", ARADDR, 0);
    repeat (2) step();
    ARESETn = 1'b1;
    RDATA = 32'hF002;
    @(negedge ACLK);
    chk("t6_drop_rd_valid", rd_valid, 0);
    chk("t6_drop_rready", RREADY, 1);
    chk("t6_req_ready", req_ready, 1);
    step();
    RDATA = 32'hF003; RLAST = 1'b1;
    @(negedge ACLK);
    chk("t6_drop_last", rd_valid, 0);
    step();
    RVALID = 1'b0; RLAST = 1'b0;
    @(negedge ACLK);
    chk("t6_out_end", outstanding, 0);
    chk("t6_perr_after", proto_err, PERR_EXP);
    chk("ar_queue_drained", exp_ar.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
